stream_mux_n: RTL and testbench
===============================

# stream_mux_n

Registered, parametrised N-to-1 stream multiplexer with valid/ready handshaking and packet locking. It generalises the team's combinational selector trees into a streaming block: any of NUM_CH input channels of DATA_W bits is routed to one output. The channel comes from an explicit select input or from round-robin arbitration, and each grant is held until the end of the current packet. It sits between multiple packet producers and a single shared consumer.

## Interface
- NUM_CH, 4: number of input channels, at least 2; need not be a power of two.
- DATA_W, 8: data width per channel.
- SEL_W, $clog2(NUM_CH): select/channel-index width; derived, never overridden.

- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- mode  input  1  0 = explicit select via sel; 1 = round-robin arbitration.
- sel  input  SEL_W  explicit channel index; used only when mode=0.
- in_data  input  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- in_valid  input  NUM_CH  per-channel valid.
- in_last  input  NUM_CH  per-channel end-of-packet marker.
- in_ready  output  NUM_CH  per-channel ready; at most one bit high.
- out_data  output  DATA_W  registered output data.
- out_valid  output  1  output valid.
- out_last  output  1  end-of-packet marker for out_data.
- out_ch  output  SEL_W  index of the channel that sourced out_data.
- out_ready  input  1  consumer ready.

## Operation
- FSM states:
  - IDLE: no grant held. mode and sel are sampled here only.
  - LOCKED: grant g is held. The registered grant index g determines routing.
- IDLE, mode=0:
  - If sel < NUM_CH and in_valid[sel]=1: set g=sel and go to LOCKED.
  - If sel >= NUM_CH: stay in IDLE with no grant.
- IDLE, mode=1:
  - Search for a valid channel starting at rr_ptr+1, modulo NUM_CH, wrapping.
  - The first channel with in_valid=1 becomes g. rr_ptr takes the value g. Go to LOCKED.
  - If no channel is valid, stay in IDLE.
- LOCKED:
  - in_ready[g] = !out_valid || out_ready. All other in_ready bits are 0.
  - A beat transfers when in_valid[g] && in_ready[g]. The output register then loads in_data[g], in_last[g] and out_ch=g, and out_valid=1.
  - When a transferred beat has in_last[g]=1, go to IDLE at that edge.
- Output register, one entry:
  - Cleared (out_valid goes to 0) when out_valid && out_ready and no new beat loads in the same cycle.
  - A simultaneous drain and load keeps out_valid=1 with the new contents.
- Reset values: state=IDLE, rr_ptr=NUM_CH-1 (first round-robin search begins at channel 0), out_valid=0, out_data=0, out_last=0, out_ch=0, in_ready=0.
- Boundary conditions:
  - in_valid[g] dropping mid-packet: stay in LOCKED and wait; there is no timeout.
  - mode or sel changing while in LOCKED: ignored until the next IDLE.
  - Valid asserted on a non-granted channel: not acknowledged; that channel's in_ready stays 0.
  - out_ready=0 with out_valid=1: out_data, out_last and out_ch remain stable, and in_ready[g]=0.
  - rst asserted mid-packet: the output register contents are discarded, state goes to IDLE, and rr_ptr is reset. The upstream packet is truncated; the producer is responsible for recovery.
  - Single-beat packet (in_last=1 on the first beat): IDLE→LOCKED→IDLE.

## Timing
- Grant latency: in_valid rises in IDLE at cycle 0; grant registers at the end of cycle 0; in_ready[g]=1 in cycle 1; out_valid=1 in cycle 2.
- Throughput in LOCKED with out_ready held high: one beat per cycle.
- Inter-packet gap: one IDLE cycle after each last beat, with all in_ready=0 during it.
- Combinational paths:
  - in_ready depends combinationally on out_ready. This is the only input-to-output combinational path.
  - out_* are driven directly from flops.

## Test plan
- Explicit select, streaming: NUM_CH=4, DATA_W=8, mode=0, sel=2, ch2 sends 0x11,0x22,0x33 with last on 0x33, out_ready=1. Required: out_data 0x11,0x22,0x33 in cycles 2-4, out_ch=2, out_last only on 0x33, and in_ready[0,1,3]=0 throughout.
- Round-robin fairness: mode=1, all channels continuously valid with 2-beat packets. Required: grant order 0,1,2,3,0, each packet contiguous, one idle cycle between packets.
- Backpressure: out_ready=0 for 3 cycles mid-packet. Required: out_data held stable, in_ready[g]=0, no beat lost or duplicated. Data resumes in order after out_ready=1.
- Lock and select stability: in LOCKED on ch1, change sel to 3 and in_valid[1] to 0 for 2 cycles. Required: grant stays on ch1 and no ch3 data appears until ch1's last beat, after which ch3 is granted.
- Out-of-range select: NUM_CH=3, mode=0, sel=3, all channels valid. Required: in_ready=0 and out_valid=0 indefinitely.
- Reset mid-packet: assert rst for 1 cycle after 2 of 4 beats. Required: the next cycle shows out_valid=0, in_ready=0 and out_ch=0. The following round-robin grant is channel 0 if it is valid.

Source files
------------

// File: rtl/stream_mux_n.sv
// N-to-1 registered stream multiplexer with explicit-select or round-robin
// arbitration; a grant is held from the first beat through the packet's last beat.
module stream_mux_n #(
   parameter  int NUM_CH = 4,
   parameter  int DATA_W = 8,
   localparam int SEL_W  = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mode,
   input  logic [SEL_W-1:0]         sel,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH-1:0]        in_last,
   output logic [NUM_CH-1:0]        in_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   output logic                     out_last,
   output logic [SEL_W-1:0]         out_ch,
   input  logic                     out_ready
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                         state;
   logic [SEL_W-1:0]               g;
   logic [SEL_W-1:0]               rr_ptr;
   logic [NUM_CH-1:0][DATA_W-1:0]  ch_data;
   logic                           slot_free;
   logic                           take;
   logic                           sel_hit;
   logic                           rr_hit;
   logic [SEL_W-1:0]               rr_idx;
   int                             cand;

   assign ch_data   = in_data;
   assign slot_free = !out_valid || out_ready;
   assign take      = (state == LOCKED) && in_valid[g] && slot_free;

   // Only the granted channel ever sees ready; the output slot gates it.
   always_comb begin
      in_ready = '0;
      if (state == LOCKED) in_ready[g] = slot_free;
   end

   // Explicit select: out-of-range indices never grant.
   always_comb begin
      sel_hit = 1'b0;
      if (int'(sel) < NUM_CH) sel_hit = in_valid[sel];
   end

   // Round-robin search starts one past the last grant and wraps once.
   always_comb begin
      rr_hit = 1'b0;
      rr_idx = '0;
      cand   = 0;
      for (int i = 1; i <= NUM_CH; i++) begin
         cand = int'(rr_ptr) + i;
         if (cand >= NUM_CH) cand = cand - NUM_CH;
         if (!rr_hit && in_valid[SEL_W'(cand)]) begin
            rr_hit = 1'b1;
            rr_idx = SEL_W'(cand);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         g         <= '0;
         rr_ptr    <= SEL_W'(NUM_CH - 1);
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_ch    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!mode) begin
                  if (sel_hit) begin
                     g     <= sel;
                     state <= LOCKED;
                  end
               end else if (rr_hit) begin
                  g      <= rr_idx;
                  rr_ptr <= rr_idx;
                  state  <= LOCKED;
               end
            end
            LOCKED: begin
               if (take && in_last[g]) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (take) begin
            out_valid <= 1'b1;
            out_data  <= ch_data[g];
            out_last  <= in_last[g];
            out_ch    <= g;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: queue-driven producers, a cycle-level reference model
// of the handshake, and per-scenario checks on the recorded output stream.
module tb_stream_mux_n;
   localparam int N = 4;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic             mode;
   logic [1:0]       sel;
   logic [N*W-1:0]   in_data;
   logic [N-1:0]     in_valid, in_last, in_ready;
   logic [W-1:0]     out_data;
   logic             out_valid, out_last, out_ready;
   logic [1:0]       out_ch;

   logic             mode3;
   logic [1:0]       sel3;
   logic [3*W-1:0]   in_data3;
   logic [2:0]       in_valid3, in_last3, in_ready3;
   logic [W-1:0]     out_data3;
   logic             out_valid3, out_last3, out_ready3;
   logic [1:0]       out_ch3;

   stream_mux_n #(.NUM_CH(N), .DATA_W(W)) dut (
      .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
      .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
      .out_ch(out_ch), .out_ready(out_ready));

   stream_mux_n #(.NUM_CH(3), .DATA_W(W)) dut3 (
      .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_data(in_data3),
      .in_valid(in_valid3), .in_last(in_last3), .in_ready(in_ready3),
      .out_data(out_data3), .out_valid(out_valid3), .out_last(out_last3),
      .out_ch(out_ch3), .out_ready(out_ready3));

   typedef struct {logic [W-1:0] d; logic l;} beat_t;
   typedef struct {int ch; logic [W-1:0] d; logic l; int cyc;} obs_t;

   beat_t q[N][$];
   beat_t sent[N][$];
   obs_t  obs[$];

   logic [N-1:0] en;
   bit   rand_en, rand_rdy, rand_sel;
   int   en_pct;
   logic rdy_fix;
   int   checks, errors, cyc;

   // reference model state
   bit          m_locked, m_ov;
   int          m_g, m_rr, m_oc;
   logic [W-1:0] m_od;
   logic        m_ol;

   task automatic model_reset();
      m_locked = 0; m_g = 0; m_rr = N - 1;
      m_ov = 0; m_od = '0; m_ol = 0; m_oc = 0;
   endtask

   function automatic bit quiet();
      bit e;
      e = !m_locked && !m_ov;
      for (int k = 0; k < N; k++) if (q[k].size() != 0) e = 0;
      return e;
   endfunction

   task automatic clear_all();
      for (int k = 0; k < N; k++) begin q[k].delete(); sent[k].delete(); end
      obs.delete();
   endtask

   task automatic add_beat(int ch, logic [W-1:0] d, logic l);
      beat_t x;
      x.d = d; x.l = l;
      q[ch].push_back(x); sent[ch].push_back(x);
   endtask

   task automatic add_pkt(int ch, int len);
      for (int b = 0; b < len; b++) add_beat(ch, W'($urandom), b == len - 1);
   endtask

   task automatic drive();
      bit v;
      for (int k = 0; k < N; k++) begin
         v = (q[k].size() > 0) && (rand_en ? ($urandom_range(0, 99) < en_pct) : en[k]);
         in_valid[k] = v;
         if (q[k].size() > 0) begin
            in_data[k*W +: W] = q[k][0].d;
            in_last[k]        = q[k][0].l;
         end else begin
            in_data[k*W +: W] = W'($urandom);
            in_last[k]        = 1'($urandom_range(0, 1));
         end
      end
      out_ready = rand_rdy ? ($urandom_range(0, 99) < 60) : rdy_fix;
      if (rand_sel) sel = 2'($urandom);
   endtask

   task automatic model_step();
      logic [N-1:0] exp_rdy;
      bit was_locked, beat;
      exp_rdy = '0;
      if (m_locked && (!m_ov || out_ready)) exp_rdy[m_g] = 1'b1;
      checks++;
      if (in_ready !== exp_rdy) begin
         errors++;
         if (errors < 40) $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy);
      end
      checks++;
      if (out_valid !== m_ov) begin
         errors++;
         if (errors < 40) $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, m_ov);
      end
      if (m_ov) begin
         checks++;
         if ({out_data, out_last, out_ch} !== {m_od, m_ol, 2'(m_oc)}) begin
            errors++;
            if (errors < 40)
               $display("FAIL out_beat cyc=%0d got=%h/%b/%0d exp=%h/%b/%0d",
                        cyc, out_data, out_last, out_ch, m_od, m_ol, m_oc);
         end
      end
      if (out_valid === 1'b1 && out_ready) obs.push_back('{int'(out_ch), out_data, out_last, cyc});
      for (int k = 0; k < N; k++)
         if (in_valid[k] && in_ready[k] === 1'b1) void'(q[k].pop_front());
      if (rst) begin
         model_reset();
      end else begin
         was_locked = m_locked;
         beat = was_locked && exp_rdy[m_g] && in_valid[m_g];
         if (beat) begin
            m_od = in_data[m_g*W +: W]; m_ol = in_last[m_g]; m_oc = m_g; m_ov = 1;
            if (in_last[m_g]) m_locked = 0;
         end else if (m_ov && out_ready) begin
            m_ov = 0;
         end
         if (!was_locked) begin
            if (mode == 1'b0) begin
               if (int'(sel) < N && in_valid[sel]) begin m_g = int'(sel); m_locked = 1; end
            end else begin
               for (int i = 1; i <= N; i++) begin
                  int c;
                  c = (m_rr + i) % N;
                  if (in_valid[c]) begin m_g = c; m_rr = c; m_locked = 1; break; end
               end
            end
         end
      end
   endtask

   task automatic tick();
      drive();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1; tick(); rst = 1'b0;
   endtask

   task automatic drain(int bound);
      int n;
      rand_en = 0; rand_rdy = 0; rand_sel = 0; rdy_fix = 1; en = '1; mode = 1;
      n = 0;
      while (!quiet() && n < bound) begin tick(); n++; end
      checks++;
      if (!quiet()) begin errors++; $display("FAIL drain_timeout cycles=%0d required=quiet", n); end
      clear_all();
   endtask

   task automatic test_reset();
      clear_all(); en = '0; rand_en = 0; rand_rdy = 0; rand_sel = 0; rdy_fix = 1;
      mode = 0; sel = 0; drive();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      tick();
      rst = 1'b0;
      checks += 5;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      if (out_data !== '0)    begin errors++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
      if (out_last !== 1'b0)  begin errors++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
      if (out_ch !== 2'd0)    begin errors++; $display("FAIL rst_out_ch got=%0d exp=0", out_ch); end
      if (in_ready !== '0)    begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
   endtask

   task automatic test_explicit_select();
      logic [W-1:0] exp_d [3];
      int start;
      exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
      clear_all();
      for (int i = 0; i < 3; i++) add_beat(2, exp_d[i], i == 2);
      add_pkt(0, 2); add_pkt(1, 2); add_pkt(3, 2);
      en = '1; mode = 0; sel = 2; rdy_fix = 1;
      start = cyc;
      repeat (8) tick();
      checks++;
      if (obs.size() != 3) begin
         errors++; $display("FAIL sel_count got=%0d exp=3", obs.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i].ch != 2 || obs[i].d !== exp_d[i] || obs[i].l !== (i == 2) ||
                obs[i].cyc != start + 2 + i) begin
               errors++;
               $display("FAIL sel_beat%0d got=ch%0d/%h/%b/c%0d exp=ch2/%h/%b/c%0d", i,
                        obs[i].ch, obs[i].d, obs[i].l, obs[i].cyc - start, exp_d[i], i == 2, 2 + i);
            end
         end
      end
      drain(200);
   endtask

   task automatic test_rr_fairness();
      clear_all();
      do_reset();
      for (int k = 0; k < N; k++) begin add_pkt(k, 2); add_pkt(k, 2); end
      en = '1; mode = 1; rdy_fix = 1;
      repeat (20) tick();
      checks++;
      if (obs.size() < 10) begin
         errors++; $display("FAIL rr_count got=%0d exp>=10", obs.size());
      end else begin
         for (int p = 0; p < 5; p++) begin
            int ch, pk;
            ch = p % N; pk = (p < N) ? 0 : 1;
            for (int b = 0; b < 2; b++) begin
               checks++;
               if (obs[2*p+b].ch != ch || obs[2*p+b].d !== sent[ch][2*pk+b].d ||
                   obs[2*p+b].l !== (b == 1)) begin
                  errors++;
                  $display("FAIL rr_pkt%0d_beat%0d got=ch%0d/%h exp=ch%0d/%h", p, b,
                           obs[2*p+b].ch, obs[2*p+b].d, ch, sent[ch][2*pk+b].d);
               end
            end
            checks++;
            if (obs[2*p+1].cyc != obs[2*p].cyc + 1) begin
               errors++; $display("FAIL rr_contig%0d got=%0d exp=1", p, obs[2*p+1].cyc - obs[2*p].cyc);
            end
            if (p > 0) begin
               checks++;
               if (obs[2*p].cyc != obs[2*p-1].cyc + 2) begin
                  errors++; $display("FAIL rr_gap%0d got=%0d exp=2", p, obs[2*p].cyc - obs[2*p-1].cyc);
               end
            end
         end
      end
      drain(200);
   endtask

   task automatic test_backpressure();
      logic [W-1:0] hold;
      int n;
      clear_all();
      add_pkt(1, 5);
      en = '1; mode = 0; sel = 1; rdy_fix = 1;
      n = 0;
      while (obs.size() < 2 && n < 20) begin tick(); n++; end
      rdy_fix = 0;
      hold = out_data;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== hold || in_ready !== '0) begin
            errors++;
            $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/%h/0000", i, out_valid, out_data, in_ready, hold);
         end
      end
      rdy_fix = 1;
      n = 0;
      while (!quiet() && n < 30) begin tick(); n++; end
      checks++;
      if (obs.size() != 5) begin
         errors++; $display("FAIL bp_count got=%0d exp=5", obs.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i].d !== sent[1][i].d || obs[i].ch != 1) begin
               errors++; $display("FAIL bp_beat%0d got=%h exp=%h", i, obs[i].d, sent[1][i].d);
            end
         end
      end
      drain(200);
   endtask

   task automatic test_lock();
      int n;
      clear_all();
      add_pkt(1, 4); add_pkt(3, 2);
      en = '1; mode = 0; sel = 1; rdy_fix = 1;
      n = 0;
      while (obs.size() < 1 && n < 20) begin tick(); n++; end
      sel = 3; en[1] = 1'b0;
      repeat (2) tick();
      en[1] = 1'b1;
      n = 0;
      while (!quiet() && n < 50) begin tick(); n++; end
      checks++;
      if (obs.size() != 6) begin
         errors++; $display("FAIL lock_count got=%0d exp=6", obs.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            int ch, idx;
            ch = (i < 4) ? 1 : 3; idx = (i < 4) ? i : i - 4;
            checks++;
            if (obs[i].ch != ch || obs[i].d !== sent[ch][idx].d) begin
               errors++; $display("FAIL lock_beat%0d got=ch%0d/%h exp=ch%0d/%h", i,
                                  obs[i].ch, obs[i].d, ch, sent[ch][idx].d);
            end
         end
      end
      drain(200);
   endtask

   task automatic test_out_of_range();
      for (int i = 0; i < 20; i++) begin
         in_data3 = 24'($urandom);
         @(negedge clk);
         checks++;
         if (in_ready3 !== 3'b000 || out_valid3 !== 1'b0) begin
            errors++; $display("FAIL oor%0d got=%b/%b exp=000/0", i, in_ready3, out_valid3);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int n;
      clear_all();
      do_reset();
      add_pkt(2, 4); add_pkt(0, 2);
      en = 4'b0100; mode = 1; rdy_fix = 1;
      n = 0;
      while (obs.size() < 2 && n < 30) begin tick(); n++; end
      en = 4'b0101;
      do_reset();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== '0 || out_ch !== 2'd0) begin
         errors++; $display("FAIL rstmid got=%b/%b/%0d exp=0/0000/0", out_valid, in_ready, out_ch);
      end
      obs.delete();
      n = 0;
      while (obs.size() < 1 && n < 20) begin tick(); n++; end
      checks++;
      if (obs.size() < 1 || obs[0].ch != 0) begin
         errors++; $display("FAIL rstmid_grant got=%0d exp=0", obs.size() ? obs[0].ch : -1);
      end
      drain(200);
   endtask

   task automatic test_random();
      for (int r = 0; r < 2; r++) begin
         int n;
         clear_all();
         for (int k = 0; k < N; k++) repeat (3) add_pkt(k, $urandom_range(1, 4));
         mode = 1'(r); rand_en = 1; en_pct = 70; rand_rdy = 1; rand_sel = (r == 0);
         n = 0;
         while (!quiet() && n < 3000) begin tick(); n++; end
         rand_en = 0; rand_rdy = 0; rand_sel = 0;
         checks++;
         if (!quiet()) begin errors++; $display("FAIL rand%0d_timeout cycles=%0d", r, n); end
         for (int k = 0; k < N; k++) begin
            int j;
            j = 0;
            foreach (obs[i]) if (obs[i].ch == k) begin
               checks++;
               if (j >= sent[k].size() || obs[i].d !== sent[k][j].d || obs[i].l !== sent[k][j].l) begin
                  errors++; $display("FAIL rand%0d_ch%0d_beat%0d got=%h", r, k, j, obs[i].d);
               end
               j++;
            end
            checks++;
            if (j != sent[k].size()) begin
               errors++; $display("FAIL rand%0d_ch%0d_count got=%0d exp=%0d", r, k, j, sent[k].size());
            end
         end
         for (int i = 1; i < obs.size(); i++) begin
            if (obs[i].ch != obs[i-1].ch) begin
               checks++;
               if (obs[i-1].l !== 1'b1) begin
                  errors++; $display("FAIL rand%0d_interleave at=%0d", r, i);
               end
            end
         end
         drain(200);
      end
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0; en_pct = 70;
      mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; in_last3 = 3'b010;
      in_data3 = '0; out_ready3 = 1'b1;
      model_reset();
      test_reset();
      test_out_of_range();
      test_explicit_select();
      test_rr_fairness();
      test_backpressure();
      test_lock();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
